// File: rtl/assoc_icache_if.sv
// CPU fetch port and refill memory port of the set-associative instruction cache.
// The cache takes the slave modport; the core/memory side takes the master modport.
interface assoc_icache_if #(
  parameter int line_size = 32
);
  logic                 read;
  logic [line_size-1:0] address;
  logic [line_size-1:0] data;
  logic                 busywait;
  logic                 mem_read;
  logic [line_size-1:0] mem_address;
  logic [line_size-1:0] mem_readdata;
  logic                 mem_ack;

  modport master (
    output read, address, mem_readdata, mem_ack,
    input  data, busywait, mem_read, mem_address
  );

  modport slave (
    input  read, address, mem_readdata, mem_ack,
    output data, busywait, mem_read, mem_address
  );
endinterface

// File: rtl/assoc_icache.sv
// Set-associative instruction cache: same-cycle hits, word-by-word block refill,
// lowest-invalid-way then per-set round-robin replacement.
module assoc_icache #(
  parameter int line_size   = 32,
  parameter int ways_log2   = 1,
  parameter int index_depth = 4,
  parameter int offset_size = 2
) (
  input  logic           clk,
  input  logic           reset,
  assoc_icache_if.slave  bus
);
  localparam int tag_size = line_size - index_depth - offset_size - 2;
  localparam int ways     = 1 << ways_log2;
  localparam int sets     = 1 << index_depth;
  localparam int words    = 1 << offset_size;
  localparam int way_w    = (ways_log2 > 0) ? ways_log2 : 1;

  typedef enum logic [1:0] {IDLE, FETCH, UPDATE} state_t;

  state_t                state;
  logic [ways-1:0]       valid    [sets];
  logic [tag_size-1:0]   tag_arr  [sets][ways];
  logic [line_size-1:0]  data_arr [sets][ways][words];

  logic [tag_size-1:0]    req_tag, fill_tag;
  logic [index_depth-1:0] req_idx, fill_idx;
  logic [offset_size-1:0] req_off, cnt;
  logic [way_w-1:0]       hit_way, victim, fill_way, rr_cur;
  logic                   hit;
  logic                   mem_read_q;
  logic [line_size-1:0]   mem_address_q;

  assign req_tag = bus.address[line_size-1 -: tag_size];
  assign req_idx = bus.address[offset_size+2 +: index_depth];
  assign req_off = bus.address[2 +: offset_size];

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < ways; w++) begin
      if (valid[req_idx][w] && (tag_arr[req_idx][w] == req_tag)) begin
        hit     = 1'b1;
        hit_way = way_w'(w);
      end
    end
  end

  // Descending scan so the lowest-numbered invalid way wins over the pointer.
  always_comb begin
    victim = rr_cur;
    for (int w = ways - 1; w >= 0; w--) begin
      if (!valid[req_idx][w]) victim = way_w'(w);
    end
  end

  generate
    if (ways_log2 > 0) begin : g_rr
      logic [ways_log2-1:0] rr_ptr [sets];

      always_ff @(posedge clk) begin
        if (reset) begin
          for (int s = 0; s < sets; s++) rr_ptr[s] <= '0;
        end else if (state == UPDATE && fill_way == rr_ptr[fill_idx]) begin
          rr_ptr[fill_idx] <= rr_ptr[fill_idx] + 1'b1;
        end
      end

      assign rr_cur = rr_ptr[req_idx];
    end else begin : g_dm
      assign rr_cur = '0;
    end
  endgenerate

  assign bus.data        = hit ? data_arr[req_idx][hit_way][req_off] : '0;
  assign bus.busywait    = (state != IDLE) || (bus.read && !hit);
  assign bus.mem_read    = mem_read_q;
  assign bus.mem_address = mem_address_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      mem_read_q    <= 1'b0;
      mem_address_q <= '0;
      for (int s = 0; s < sets; s++) valid[s] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.read && !hit) begin
            state                  <= FETCH;
            fill_tag               <= req_tag;
            fill_idx               <= req_idx;
            fill_way               <= victim;
            cnt                    <= '0;
            valid[req_idx][victim] <= 1'b0;
            mem_read_q             <= 1'b1;
            mem_address_q          <= {req_tag, req_idx, {offset_size{1'b0}}, 2'b00};
          end
        end
        FETCH: begin
          if (bus.mem_ack) begin
            cnt <= cnt + 1'b1;
            if (cnt == offset_size'(words - 1)) begin
              state         <= UPDATE;
              mem_read_q    <= 1'b0;
              mem_address_q <= '0;
            end else begin
              mem_address_q <= {fill_tag, fill_idx, cnt + 1'b1, 2'b00};
            end
          end
        end
        UPDATE: begin
          valid[fill_idx][fill_way] <= 1'b1;
          state                     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Storage arrays carry no reset; validity alone decides whether contents are used.
  always_ff @(posedge clk) begin
    if (state == FETCH && bus.mem_ack) data_arr[fill_idx][fill_way][cnt] <= bus.mem_readdata;
    if (state == UPDATE) tag_arr[fill_idx][fill_way] <= fill_tag;
  end
endmodule

// File: tb/tb_assoc_icache.sv
// Bench for assoc_icache: block-level cache model checked every cycle on the default
// configuration, plus directed literal checks on both a 2-way and a direct-mapped build.
module tb_assoc_icache;
  logic clk;
  logic reset;

  assoc_icache_if #(.line_size(32)) ifa ();
  assoc_icache_if #(.line_size(32)) ifb ();

  assoc_icache #(.line_size(32), .ways_log2(1), .index_depth(4), .offset_size(2)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa)
  );
  assoc_icache #(.line_size(32), .ways_log2(0), .index_depth(6), .offset_size(3)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  bit chk_on = 1'b0;

  int gap_a = 0;
  bit stray_a = 1'b0;
  int ack_cnt_a = 0;
  logic [31:0] ack_log_a[$];
  logic [31:0] ack_log_b[$];

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] r;
    r = (32'($urandom_range(0, 5)) << 8) | (32'($urandom_range(0, 3)) << 4) |
        (32'($urandom_range(0, 3)) << 2);
    return r;
  endfunction

  // Memory for the default build: optional gaps between acks, optional stray acks.
  initial begin
    int idle_ct;
    idle_ct = 0;
    ifa.mem_ack = 1'b0;
    ifa.mem_readdata = '0;
    forever begin
      @(negedge clk);
      ifa.mem_ack = 1'b0;
      if (ifa.mem_read) begin
        if ((gap_a < 0) ? ($urandom_range(0, 1) == 1) : (idle_ct >= gap_a)) begin
          ifa.mem_ack = 1'b1;
          ifa.mem_readdata = memf(ifa.mem_address);
          ack_cnt_a++;
          ack_log_a.push_back(ifa.mem_address);
          idle_ct = 0;
        end else begin
          idle_ct++;
        end
      end else begin
        idle_ct = 0;
        if (stray_a && $urandom_range(0, 3) == 0) begin
          ifa.mem_ack = 1'b1;
          ifa.mem_readdata = $urandom;
        end
      end
    end
  end

  initial begin
    ifb.mem_ack = 1'b0;
    ifb.mem_readdata = '0;
    forever begin
      @(negedge clk);
      ifb.mem_ack = ifb.mem_read;
      if (ifb.mem_read) begin
        ifb.mem_readdata = memf(ifb.mem_address);
        ack_log_b.push_back(ifb.mem_address);
      end
    end
  end

  // Model of the default build: which memory block sits in each way of each set.
  int way_blk [16][2];
  int ptr [16];
  int ph = 0;
  int fs, fv, fb;
  logic [31:0] fq[$];

  function automatic bit model_hit(input logic [31:0] a);
    int s;
    s = int'(a[7:4]);
    return (way_blk[s][0] == int'(a[31:4])) || (way_blk[s][1] == int'(a[31:4]));
  endfunction

  initial begin
    bit exp_hit, exp_busy;
    int s, v;
    for (int i = 0; i < 16; i++) begin
      way_blk[i][0] = -1; way_blk[i][1] = -1; ptr[i] = 0;
    end
    forever begin
      @(negedge clk);
      #2;
      exp_hit  = model_hit(ifa.address);
      exp_busy = (ph != 0) || (ifa.read && !exp_hit);
      if (chk_on) begin
        check("busywait", ifa.busywait, exp_busy);
        check("mem_read", ifa.mem_read, ph == 1);
        if (ph == 1) check("mem_address", ifa.mem_address, fq[0]);
        if (ifa.read && !exp_busy) check("hit_data", ifa.data, memf({ifa.address[31:2], 2'b00}));
      end
      if (reset) begin
        for (int i = 0; i < 16; i++) begin
          way_blk[i][0] = -1; way_blk[i][1] = -1; ptr[i] = 0;
        end
        ph = 0;
        fq.delete();
      end else if (ph == 0) begin
        if (ifa.read && !exp_hit) begin
          s = int'(ifa.address[7:4]);
          v = (way_blk[s][0] < 0) ? 0 : (way_blk[s][1] < 0) ? 1 : ptr[s];
          way_blk[s][v] = -1;
          fs = s; fv = v; fb = int'(ifa.address[31:4]);
          for (int k = 0; k < 4; k++) fq.push_back({ifa.address[31:4], 4'(k * 4)});
          ph = 1;
        end
      end else if (ph == 1) begin
        if (ifa.mem_ack) begin
          void'(fq.pop_front());
          if (fq.size() == 0) ph = 2;
        end
      end else begin
        way_blk[fs][fv] = fb;
        if (fv == ptr[fs]) ptr[fs] = (ptr[fs] + 1) % 2;
        ph = 0;
      end
    end
  end

  task automatic drive(input bit b, input bit r, input logic [31:0] a);
    if (b) begin ifb.read = r; ifb.address = a; end
    else   begin ifa.read = r; ifa.address = a; end
  endtask

  // Issue one fetch and hold it until busywait drops; n = busy cycles seen.
  task automatic req(input bit b, input logic [31:0] a, input int tog, input bit rr,
                     output int n, output logic [31:0] d);
    bit done;
    n = 0; done = 1'b0; d = '0;
    @(negedge clk);
    reset = 1'b0;
    drive(b, 1'b1, a);
    while (!done) begin
      #2;
      if (!(b ? ifb.busywait : ifa.busywait)) begin
        d = b ? ifb.data : ifa.data;
        done = 1'b1;
      end else if (n >= 200) begin
        vectors++; miscompares++;
        $display("FAIL req_timeout: address %h still busy after %0d cycles", a, n);
        done = 1'b1;
      end else begin
        n++;
        @(negedge clk);
        reset = rr && ($urandom_range(0, 39) == 0);
        drive(b, 1'b1, (n <= tog && !b) ? rand_addr() : a);
      end
    end
  endtask

  initial begin
    int n, k;
    logic [31:0] d;
    reset = 1'b1;
    drive(0, 0, '0);
    drive(1, 0, '0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk_on = 1'b1;
    #2;
    check("rst_busy_a", ifa.busywait, 0);
    check("rst_mem_read_a", ifa.mem_read, 0);
    check("rst_mem_addr_a", ifa.mem_address, 0);
    check("rst_mem_addr_b", ifb.mem_address, 0);

    ack_log_a.delete();
    req(0, 32'h40, 0, 0, n, d);
    check("miss40_busy_cycles", n, 6);
    check("miss40_data", d, 32'hDEAD_0040);
    check("miss40_ack_count", ack_log_a.size(), 4);
    for (int i = 0; i < 4 && i < ack_log_a.size(); i++)
      check("miss40_mem_address", ack_log_a[i], 32'h40 + 32'(4 * i));

    req(0, 32'h48, 0, 0, n, d);
    check("hit48_busy_cycles", n, 0);
    check("hit48_data", d, 32'hDEAD_0048);
    check("hit48_mem_read", ifa.mem_read, 0);

    req(0, 32'h440, 0, 0, n, d);
    check("miss440_busy_cycles", n, 6);
    req(0, 32'h840, 0, 0, n, d);
    check("miss840_busy_cycles", n, 6);
    req(0, 32'h440, 0, 0, n, d);
    check("hit440_busy_cycles", n, 0);
    check("hit440_data", d, 32'hDEAD_0440);
    req(0, 32'h40, 0, 0, n, d);
    check("remiss40_busy_cycles", n, 6);

    gap_a = 2;
    req(0, 32'h1044, 6, 0, n, d);
    check("gap_busy_cycles", n, 14);
    check("gap_data", d, 32'hDEAD_1044);
    gap_a = 0;

    ack_cnt_a = 0;
    @(negedge clk);
    drive(0, 1, 32'h2080);
    k = 0;
    while (ack_cnt_a < 2 && k < 20) begin
      @(negedge clk);
      #1;
      k++;
    end
    check("abort_second_ack", ack_cnt_a, 2);
    reset = 1'b1;
    drive(0, 0, 32'h2080);
    @(negedge clk);
    reset = 1'b0;
    #2;
    check("abort_mem_read", ifa.mem_read, 0);
    req(0, 32'h2080, 0, 0, n, d);
    check("abort_remiss_cycles", n, 6);

    gap_a = -1;
    stray_a = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        reset = 1'b0;
        drive(0, 0, rand_addr());
      end
      req(0, rand_addr(), int'($urandom_range(0, 3)), 1'b1, n, d);
    end
    @(negedge clk);
    reset = 1'b0;
    drive(0, 0, '0);
    gap_a = 0;
    stray_a = 1'b0;

    ack_log_b.delete();
    req(1, 32'h40, 0, 0, n, d);
    check("dm_miss40_busy_cycles", n, 10);
    check("dm_miss40_data", d, 32'hDEAD_0040);
    check("dm_ack_count", ack_log_b.size(), 8);
    for (int i = 0; i < 8 && i < ack_log_b.size(); i++)
      check("dm_mem_address", ack_log_b[i], 32'h40 + 32'(4 * i));
    req(1, 32'h48, 0, 0, n, d);
    check("dm_hit48_busy_cycles", n, 0);
    check("dm_hit48_data", d, 32'hDEAD_0048);
    check("dm_hit48_mem_read", ifb.mem_read, 0);
    req(1, 32'h5C, 0, 0, n, d);
    check("dm_hit5c_data", d, 32'hDEAD_005C);
    req(1, 32'h840, 0, 0, n, d);
    check("dm_conflict_busy_cycles", n, 10);
    req(1, 32'h40, 0, 0, n, d);
    check("dm_evicted_busy_cycles", n, 10);
    @(negedge clk);
    drive(1, 0, '0);
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, %0d miscompares so far", miscompares);
    $fatal(1, "watchdog expired");
  end
endmodule
